axi_reg_bridge: RTL and testbench

- AXI4 slave to single-port register-bus bridge; sits directly upstream of the SoC controller register file.
- Converts AXI4 read and write bursts into single-beat register accesses.
- Register bus: write is same-cycle; read data returns one cycle after the address (registered target).
- Serialises reads and writes through one FSM with round-robin arbitration.

---
 rtl/axi_reg_bridge.sv | 173 +++++++++++++++++
 tb/tb_axi_reg_bridge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_bridge.sv
// AXI4 slave to single-port register bus bridge. Bursts are split into single-beat
// register accesses; reads and writes share one FSM with round-robin arbitration.
module axi_reg_bridge #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [63:0]           i_wdata,
  input  logic [7:0]            i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [63:0]           o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_reg_we,
  output logic                  o_reg_re,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [7:0]            o_reg_be,
  output logic [63:0]           o_reg_wdata,
  input  logic [63:0]           i_reg_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WRESP, S_RADDR, S_RCAPT, S_RDATA
  } state_t;

  state_t                state, state_nxt;
  logic                  prefer_wr;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_step, addr_next;
  logic [7:0]            len_q, cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [63:0]           rdata_q;
  logic [3:0]            nbytes;
  logic                  grant_wr, grant_rd, aw_hs, ar_hs, w_hs, r_hs, last_beat;

  // When both channels request, the side not granted last wins.
  assign grant_wr  = i_awvalid && (!i_arvalid || prefer_wr);
  assign grant_rd  = i_arvalid && (!i_awvalid || !prefer_wr);
  assign aw_hs     = (state == S_IDLE) && grant_wr;
  assign ar_hs     = (state == S_IDLE) && grant_rd;
  assign w_hs      = (state == S_WDATA) && i_wvalid;
  assign r_hs      = (state == S_RDATA) && i_rready;
  assign last_beat = (cnt_q == len_q);

  // WRAP is handled as INCR; FIXED keeps the address.
  always_comb begin
    nbytes = 4'd8;
    case (size_q)
      3'd0:    nbytes = 4'd1;
      3'd1:    nbytes = 4'd2;
      3'd2:    nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
    addr_step = '0;
    if (burst_q != 2'b00) addr_step = {{(ADDR_WIDTH-4){1'b0}}, nbytes};
    addr_next = addr_q + addr_step;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (aw_hs) state_nxt = S_WDATA;
               else if (ar_hs) state_nxt = S_RADDR;
      S_WDATA: if (w_hs && last_beat) state_nxt = S_WRESP;
      S_WRESP: if (i_bready) state_nxt = S_IDLE;
      S_RADDR: state_nxt = S_RCAPT;
      S_RCAPT: state_nxt = S_RDATA;
      S_RDATA: if (r_hs) state_nxt = last_beat ? S_IDLE : S_RADDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_awready   = aw_hs;
    o_arready   = ar_hs;
    o_wready    = (state == S_WDATA);
    o_reg_we    = w_hs;
    o_reg_re    = (state == S_RADDR);
    o_bvalid    = (state == S_WRESP);
    o_bid       = id_q;
    o_bresp     = (state == S_WRESP && err_q) ? 2'b10 : 2'b00;
    o_rvalid    = (state == S_RDATA);
    o_rid       = id_q;
    o_rresp     = 2'b00;
    o_rlast     = (state == S_RDATA) && last_beat;
    o_rdata     = rdata_q;
    o_reg_addr  = (state == S_IDLE) ? '0 : addr_q;
    o_reg_wdata = i_wdata;
    o_reg_be    = 8'h00;
    if (state == S_WDATA) o_reg_be = i_wstrb;
    else if (state == S_RADDR || state == S_RCAPT) o_reg_be = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_wr <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (aw_hs) begin
        id_q      <= i_awid;
        addr_q    <= i_awaddr;
        len_q     <= i_awlen;
        size_q    <= i_awsize;
        burst_q   <= i_awburst;
        cnt_q     <= '0;
        err_q     <= 1'b0;
        prefer_wr <= 1'b0;
      end
      if (ar_hs) begin
        id_q      <= i_arid;
        addr_q    <= i_araddr;
        len_q     <= i_arlen;
        size_q    <= i_arsize;
        burst_q   <= i_arburst;
        cnt_q     <= '0;
        err_q     <= 1'b0;
        prefer_wr <= 1'b1;
      end
      // The beat counter decides where the burst ends; wlast is only cross-checked.
      if (w_hs) begin
        if (i_wlast != last_beat) err_q <= 1'b1;
        if (!last_beat) begin
          addr_q <= addr_next;
          cnt_q  <= cnt_q + 8'd1;
        end
      end
      if (state == S_RCAPT) rdata_q <= i_reg_rdata;
      if (r_hs && !last_beat) begin
        addr_q <= addr_next;
        cnt_q  <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Directed bench for axi_reg_bridge: a transaction table plus hand-written
// arbitration and reset-abort sequences against a registered register target.
module tb_axi_reg_bridge;
  localparam int IW = 1;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr, reg_addr;
  logic [7:0]    awlen, arlen, wstrb, reg_be;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready, reg_we, reg_re;
  logic [63:0]   wdata, rdata, reg_wdata, reg_rdata;

  int n_vec = 0;
  int n_err = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  axi_reg_bridge #(.ID_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
    .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid),
    .o_wready(wready), .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid),
    .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
    .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast),
    .o_rvalid(rvalid), .i_rready(rready),
    .o_reg_we(reg_we), .o_reg_re(reg_re), .o_reg_addr(reg_addr),
    .o_reg_be(reg_be), .o_reg_wdata(reg_wdata), .i_reg_rdata(reg_rdata)
  );

  // Registered target: data depends on the address presented with reg_re.
  always @(posedge clk) if (reg_re) reg_rdata <= {~reg_addr, reg_addr};

  always @(negedge clk) if (reg_we && reg_re) overlap++;

  typedef struct {
    bit          is_wr;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          bad;
    int          stall;
    logic [AW-1:0] exp_last;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tv[9];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] step(input logic [1:0] b, input logic [2:0] s);
    if (b == 2'b00) return '0;
    return (s > 3'd3) ? 32'd8 : (32'd1 << s);
  endfunction

  task automatic wr_txn(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input int bad,
                        input logic [AW-1:0] exp_last, input logic [1:0] exp_resp);
    int t = 0;
    logic [AW-1:0] a;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    #1;
    while (!awready && t < 50) begin tick(); t++; end
    chk("awready", awready, 1);
    if (!awready) begin awvalid = 1'b0; return; end
    tick();
    awvalid = 1'b0;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      wdata  = {32'hC0DE0000 + 32'(b), addr};
      wstrb  = 8'hFF ^ 8'(b);
      wlast  = (b == int'(len)) ^ (b == bad);
      wvalid = 1'b1;
      #1;
      chk("wready", wready, 1);
      chk("reg_we", reg_we, 1);
      chk("reg_re_w", reg_re, 0);
      chk("reg_addr_w", reg_addr, a);
      chk("reg_be_w", reg_be, wstrb);
      chk("reg_wdata", reg_wdata, wdata);
      if (b == int'(len)) chk("w_last_addr", reg_addr, exp_last);
      tick();
      a = a + step(burst, size);
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("wready_off", wready, 0);
    chk("reg_we_off", reg_we, 0);
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_off", bvalid, 0);
  endtask

  task automatic rd_txn(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input int stall,
                        input int abort_beat, input logic [AW-1:0] exp_last);
    int t = 0;
    logic [AW-1:0] a;
    logic [63:0] held;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    #1;
    while (!arready && t < 50) begin tick(); t++; end
    chk("arready", arready, 1);
    if (!arready) begin arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      chk("reg_re", reg_re, 1);
      chk("reg_we_r", reg_we, 0);
      chk("reg_addr_r", reg_addr, a);
      chk("reg_be_r", reg_be, 8'hFF);
      chk("rvalid_raddr", rvalid, 0);
      if (b == int'(len)) chk("r_last_addr", reg_addr, exp_last);
      if (b == abort_beat) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_rvalid", rvalid, 0);
        chk("abort_arready", arready, 0);
        chk("abort_reg_addr", reg_addr, 0);
        chk("abort_reg_re", reg_re, 0);
        chk("abort_rdata", rdata, 0);
        tick();
        chk("abort_rvalid2", rvalid, 0);
        return;
      end
      tick();
      chk("reg_re_capt", reg_re, 0);
      chk("reg_addr_capt", reg_addr, a);
      chk("rvalid_capt", rvalid, 0);
      tick();
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, {~a, a});
      chk("rid", rid, id);
      chk("rresp", rresp, 0);
      chk("rlast", rlast, b == int'(len));
      held = rdata;
      for (int k = 0; k < stall; k++) begin
        tick();
        chk("rvalid_stall", rvalid, 1);
        chk("rdata_stable", rdata, held);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      a = a + step(burst, size);
    end
    chk("rvalid_done", rvalid, 0);
  endtask

  initial begin
    tv[0] = '{1, 1'b1, 32'h10,       8'd0,   3'd3, 2'b01, -1, 0, 32'h10,  2'b00};
    tv[1] = '{0, 1'b0, 32'h28,       8'd3,   3'd3, 2'b01, -1, 0, 32'h40,  2'b00};
    tv[2] = '{0, 1'b1, 32'h20,       8'd2,   3'd3, 2'b00, -1, 5, 32'h20,  2'b00};
    tv[3] = '{1, 1'b0, 32'h100,      8'd1,   3'd3, 2'b01,  0, 0, 32'h108, 2'b10};
    tv[4] = '{1, 1'b1, 32'h200,      8'd3,   3'd2, 2'b10, -1, 0, 32'h20C, 2'b00};
    tv[5] = '{0, 1'b0, 32'hFFFFFFF8, 8'd1,   3'd3, 2'b01, -1, 0, 32'h0,   2'b00};
    tv[6] = '{0, 1'b1, 32'h40,       8'd2,   3'd5, 2'b01, -1, 1, 32'h50,  2'b00};
    tv[7] = '{1, 1'b0, 32'h300,      8'd255, 3'd0, 2'b01, -1, 0, 32'h3FF, 2'b00};
    tv[8] = '{0, 1'b1, 32'h7,        8'd0,   3'd1, 2'b01, -1, 0, 32'h7,   2'b00};

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; reg_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_reg_addr", reg_addr, 0);

    // Both channels pending each time: grants must alternate starting with write.
    for (int i = 0; i < 4; i++) begin
      awid = 1'b1; awaddr = 32'h400 + 32'(i * 16); awlen = 8'd0; awsize = 3'd3; awburst = 2'b01;
      arid = 1'b0; araddr = 32'h500 + 32'(i * 16); arlen = 8'd1; arsize = 3'd3; arburst = 2'b01;
      awvalid = 1'b1; arvalid = 1'b1;
      #1;
      chk("arb_awready", awready, (i % 2) == 0);
      chk("arb_arready", arready, (i % 2) == 1);
      if ((i % 2) == 0) wr_txn(1'b1, 32'h400 + 32'(i * 16), 8'd0, 3'd3, 2'b01, -1, 32'h400 + 32'(i * 16), 2'b00);
      else rd_txn(1'b0, 32'h500 + 32'(i * 16), 8'd1, 3'd3, 2'b01, 0, -1, 32'h508 + 32'(i * 16));
    end
    awvalid = 1'b0;
    arvalid = 1'b0;
    tick();

    foreach (tv[i]) begin
      if (tv[i].is_wr)
        wr_txn(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, tv[i].bad,
               tv[i].exp_last, tv[i].exp_resp);
      else
        rd_txn(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, tv[i].stall,
               -1, tv[i].exp_last);
    end

    // Reset during beat 2 of a 4-beat read, then a clean single read.
    rd_txn(1'b0, 32'h80, 8'd3, 3'd3, 2'b01, 0, 2, 32'h98);
    rd_txn(1'b1, 32'h90, 8'd0, 3'd3, 2'b01, 0, -1, 32'h90);

    chk("we_re_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
